// File: rtl/feistel_seq_pkg.sv
// Shared definitions for the Feistel round sequencer.
//   BLK_W       : width of a block half and of the key
//   IDX_W       : width of the round index
//   seq_state_t : sequencer FSM state
//   rotl_blk    : left-rotate a BLK_W word by any amount (taken modulo BLK_W)
package feistel_seq_pkg;

    localparam int BLK_W = 48;
    localparam int IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic logic [BLK_W-1:0] rotl_blk(input logic [BLK_W-1:0] x,
                                                  input int unsigned      n);
        int unsigned s;
        s = n % BLK_W;
        if (s == 0) return x;
        return (x << s) | (x >> (BLK_W - s));
    endfunction

endpackage

// File: rtl/feistel_keysched.sv
// Round-key generator.
//   clk, rst_n : clock, synchronous active-low reset (key cleared)
//   load       : capture in_key / decrypt at block acceptance
//   step       : advance to the next round key
//   decrypt    : direction latched on load
//   in_key     : master key
//   key        : current round key (registered)
// Encrypt starts at the master key and rotates left KEY_ROT per round.
// Decrypt starts at the last encrypt key and rotates right KEY_ROT per round,
// so the same keys are produced in reverse order.
module feistel_keysched
    import feistel_seq_pkg::*;
#(
    parameter int NUM_ROUNDS = 16,
    parameter int KEY_ROT    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             decrypt,
    input  logic [BLK_W-1:0] in_key,
    output logic [BLK_W-1:0] key
);

    localparam int unsigned START_ROT = (KEY_ROT * (NUM_ROUNDS - 1)) % BLK_W;
    localparam int unsigned STEP_ROT  = KEY_ROT % BLK_W;
    localparam int unsigned BACK_ROT  = (BLK_W - STEP_ROT) % BLK_W;

    logic dec_mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key      <= '0;
            dec_mode <= 1'b0;
        end else if (load) begin
            key      <= decrypt ? rotl_blk(in_key, START_ROT) : in_key;
            dec_mode <= decrypt;
        end else if (step) begin
            key <= dec_mode ? rotl_blk(key, BACK_ROT) : rotl_blk(key, STEP_ROT);
        end
    end

endmodule

// File: rtl/feistel_round_sequencer.sv
// Sequences NUM_ROUNDS Feistel rounds through an external round datapath.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : block-input handshake (ready only while idle)
//   in_l, in_r, in_key  : block halves and master key, sampled on accept
//   in_decrypt          : use round keys in reverse order
//   out_valid/out_ready : result handshake, result held until taken
//   out_l, out_r        : result halves (no final swap)
//   dp_li, dp_ri, dp_ki : registered inputs to the round datapath
//   dp_lio, dp_rio      : round datapath results, captured at round end
//   abort               : cancel the block in flight (RUN only)
//   busy                : high in RUN and DONE
//   round_idx           : current round, 0 while idle
// Each round lasts RND_LAT+1 cycles so the datapath result has settled by
// the final edge of the round.
module feistel_round_sequencer
    import feistel_seq_pkg::*;
#(
    parameter int NUM_ROUNDS = 16,
    parameter int RND_LAT    = 1,
    parameter int KEY_ROT    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_l,
    input  logic [BLK_W-1:0] in_r,
    input  logic [BLK_W-1:0] in_key,
    input  logic             in_decrypt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_l,
    output logic [BLK_W-1:0] out_r,
    output logic [BLK_W-1:0] dp_li,
    output logic [BLK_W-1:0] dp_ri,
    output logic [BLK_W-1:0] dp_ki,
    input  logic [BLK_W-1:0] dp_lio,
    input  logic [BLK_W-1:0] dp_rio,
    input  logic             abort,
    output logic             busy,
    output logic [IDX_W-1:0] round_idx
);

    localparam int LAT_W = 3;

    seq_state_t       state;
    logic [BLK_W-1:0] blk_l;
    logic [BLK_W-1:0] blk_r;
    logic [BLK_W-1:0] round_key;
    logic [LAT_W-1:0] wait_cnt;
    logic             round_end;
    logic             last_round;
    logic             key_load;
    logic             key_step;

    assign round_end  = (state == RUN) && (wait_cnt == LAT_W'(RND_LAT));
    assign last_round = (round_idx == IDX_W'(NUM_ROUNDS - 1));
    assign key_load   = (state == IDLE) && in_valid;
    assign key_step   = round_end && !abort;

    feistel_keysched #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .KEY_ROT    (KEY_ROT)
    ) u_keysched (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (key_load),
        .step    (key_step),
        .decrypt (in_decrypt),
        .in_key  (in_key),
        .key     (round_key)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            blk_l     <= '0;
            blk_r     <= '0;
            round_idx <= '0;
            wait_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        blk_l     <= in_l;
                        blk_r     <= in_r;
                        round_idx <= '0;
                        wait_cnt  <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        round_idx <= '0;
                        wait_cnt  <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (round_end) begin
                        blk_l     <= dp_lio;
                        blk_r     <= dp_rio;
                        wait_cnt  <= '0;
                        round_idx <= round_idx + IDX_W'(1);
                        if (last_round) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + LAT_W'(1);
                    end
                end
                DONE: begin
                    // round_idx keeps its final count until the result is taken
                    if (out_ready) begin
                        round_idx <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dp_li = blk_l;
    assign dp_ri = blk_r;
    assign dp_ki = round_key;
    assign out_l = blk_l;
    assign out_r = blk_r;

endmodule
